spi_xfer_arbiter: RTL and testbench
===================================

# spi_xfer_arbiter

Round-robin transfer scheduler that shares one `spi_core` master datapath among `NUM_REQ` byte-level requesters. It grants one requester at a time and drives that requester's active-low slave select. It presents the tx byte to the core, pulses the core's start, waits for the core's completion, then returns the received byte with a one-cycle acknowledge. It sits between the bus-side requesters and `spi_core` (`spi_dr_in`, `new_tx_in`, `finished_out`, `shift_out`).

## Interface
- `NUM_REQ`, default 4: number of requesters (2..8).
- `TIMEOUT`, default 1023: max cycles in BUSY before forced completion. 10-bit counter.
- `clk_in` input 1: system clock, all logic on rising edge.
- `rstn_in` input 1: reset, asynchronous, active-low.
- `req_in` input NUM_REQ: level request per requester. Held high until its ack.
- `req_data_in` input 8*NUM_REQ: tx byte of requester i on bits [8i+7:8i].
- `grant_out` output NUM_REQ: one-hot, the requester currently owning the core. All zeros when free.
- `ack_out` output NUM_REQ: one-cycle pulse to the granted requester at completion.
- `rx_data_out` output 8: received byte. Valid in the ack cycle, held until the next ack.
- `timeout_out` output 1: one-cycle pulse with an ack caused by timeout.
- `ss_out` output NUM_REQ: active-low slave selects. Bit i is low only while requester i is granted.
- `core_enable_in` input 1: core usable (SPE && MTSR && !SPISWAI).
- `spi_dr_out` output 8: byte to `spi_core.spi_dr_in`.
- `new_tx_out` output 1: one-cycle start pulse to `spi_core.new_tx_in`.
- `finished_in` input 1: `spi_core.finished_out`, treated as level. Only its rising edge counts.
- `shift_in` input 8: `spi_core.shift_out`.

## Operation
- States: IDLE, GRANT, START, BUSY, DONE. Registered FSM, all outputs registered.
- IDLE: if `core_enable_in` and any `req_in` bit is set, select a winner:
  - Winner is the first set bit at or above `rr_ptr`, wrapping modulo NUM_REQ.
  - Latch the winner index and its `req_data_in` byte. Go to GRANT.
- GRANT (1 cycle): `grant_out` and `ss_out` reflect the winner. `spi_dr_out` = latched byte. Go to START.
- START (1 cycle): `new_tx_out` = 1. Clear timeout counter. Capture `finished_in` into `fin_d`. Go to BUSY.
- BUSY: increment timeout counter every cycle.
  - `finished_in && !fin_d` → latch `shift_in` into `rx_data_out`. Go to DONE.
  - Counter == TIMEOUT → `rx_data_out` = 8'h00, set timeout flag. Go to DONE.
  - If both happen in the same cycle, the finish wins and no timeout is flagged.
- DONE (1 cycle):
  - `ack_out[winner]` = 1. `timeout_out` = timeout flag.
  - Release `grant_out` to 0 and `ss_out` to all ones.
  - `rr_ptr` = (winner+1) mod NUM_REQ. Go to IDLE.
- Abort: `core_enable_in` low in GRANT, START or BUSY:
  - Next cycle: IDLE, grant and ss released.
  - No ack, no timeout pulse. `rr_ptr` unchanged. The requester keeps its req and is re-arbitrated.
- Request changes after the latch in IDLE have no effect on the current transfer.
- A `req_in` bit dropped before ack aborts nothing. That requester still receives its ack.
- `finished_in` rising outside BUSY is ignored.

## Timing
- Reset values:
  - FSM = IDLE, `rr_ptr` = 0.
  - `grant_out` = 0, `ack_out` = 0, `rx_data_out` = 8'h00, `timeout_out` = 0, `new_tx_out` = 0, `spi_dr_out` = 8'h00.
  - `ss_out` = all ones.
- Reset mid-transfer forces reset values immediately (asynchronous).
- From a request sampled in IDLE at edge 0:
  - Edge 1: `grant_out`/`ss_out` valid.
  - Edge 2: `new_tx_out` high for one cycle.
  - Edge 3: enter BUSY.
- Finish edge seen at edge k: DONE at k+1, `ack_out` high for cycle k+1, IDLE at k+2.
- Back-to-back: next grant at the earliest 2 edges after the ack. `ss_out` is high for at least 1 full cycle between transfers.
- Minimum transfer overhead: 5 cycles excluding core time.

## Test plan
- Single request: `req_in`=4'b0100, data 8'hA5. Core echoes `shift_in`=8'h3C with a finish pulse 20 cycles after start. Expect:
  - `ss_out`=4'b1011 from edge 1.
  - `spi_dr_out`=8'hA5 and `new_tx_out` one pulse at edge 2.
  - `ack_out`=4'b0100 with `rx_data_out`=8'h3C.
  - `ss_out`=4'b1111 after.
- Round-robin: all four req held for 8 transfers → grant order 0,1,2,3,0,1,2,3. Each requester gets exactly two acks.
- Timeout: TIMEOUT=15, `finished_in` stuck low. Expect:
  - DONE 16 cycles after entering BUSY.
  - `ack_out` and `timeout_out` pulse together, `rx_data_out`=8'h00.
- Abort: drop `core_enable_in` mid-BUSY. Expect:
  - `ss_out`=all ones next cycle, no ack, `rr_ptr` unchanged.
  - Re-raising enable re-grants the same requester.
- Stale finish: `finished_in` already high when START occurs → no completion until it falls and rises again. Async reset asserted in BUSY → all outputs at reset values before the next clock edge.

Source files
------------

// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin scheduler sharing one spi_core among byte requesters
module spi_xfer_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic                 clk_in,
    input  logic                 rstn_in,
    input  logic [NUM_REQ-1:0]   req_in,
    input  logic [8*NUM_REQ-1:0] req_data_in,
    output logic [NUM_REQ-1:0]   grant_out,
    output logic [NUM_REQ-1:0]   ack_out,
    output logic [7:0]           rx_data_out,
    output logic                 timeout_out,
    output logic [NUM_REQ-1:0]   ss_out,
    input  logic                 core_enable_in,
    output logic [7:0]           spi_dr_out,
    output logic                 new_tx_out,
    input  logic                 finished_in,
    input  logic [7:0]           shift_in
);
    localparam int PW = $clog2(NUM_REQ);
    typedef enum logic [2:0] {IDLE, GRANT, START, BUSY, DONE} state_t;
    state_t state;
    logic [PW-1:0] rr_ptr, win_q, win_idx, off;
    logic [PW:0] sum;
    logic [NUM_REQ-1:0] rot;
    logic [9:0] cnt;
    logic fin_d;

    // rotate requests so rr_ptr lands on bit 0, pick the lowest set bit, rotate back
    always_comb begin
        rot = NUM_REQ'({req_in, req_in} >> rr_ptr);
        off = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (rot[k]) off = PW'(k);
        sum = {1'b0, rr_ptr} + {1'b0, off};
        win_idx = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : sum[PW-1:0];
    end

    // transfer sequencer; every output is a register, pulses default low each cycle
    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            win_q       <= '0;
            cnt         <= '0;
            fin_d       <= 1'b0;
            grant_out   <= '0;
            ack_out     <= '0;
            rx_data_out <= 8'h00;
            timeout_out <= 1'b0;
            ss_out      <= '1;
            spi_dr_out  <= 8'h00;
            new_tx_out  <= 1'b0;
        end else begin
            ack_out     <= '0;
            timeout_out <= 1'b0;
            new_tx_out  <= 1'b0;
            case (state)
                IDLE: if (core_enable_in && |req_in) begin
                    state      <= GRANT;
                    win_q      <= win_idx;
                    grant_out  <= NUM_REQ'(1) << win_idx;
                    ss_out     <= ~(NUM_REQ'(1) << win_idx);
                    spi_dr_out <= req_data_in[{win_idx, 3'b000} +: 8];
                end
                GRANT: begin
                    state      <= START;
                    new_tx_out <= 1'b1;
                end
                START: begin
                    state <= BUSY;
                    cnt   <= '0;
                    fin_d <= finished_in;
                end
                BUSY: begin
                    cnt   <= cnt + 10'd1;
                    fin_d <= finished_in;
                    if (finished_in && !fin_d) begin
                        state       <= DONE;
                        rx_data_out <= shift_in;
                        ack_out     <= grant_out;
                    end else if (cnt == 10'(TIMEOUT)) begin
                        state       <= DONE;
                        rx_data_out <= 8'h00;
                        ack_out     <= grant_out;
                        timeout_out <= 1'b1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    grant_out <= '0;
                    ss_out    <= '1;
                    rr_ptr    <= (win_q == PW'(NUM_REQ - 1)) ? '0 : win_q + 1'b1;
                end
                default: state <= IDLE;
            endcase
            if (!core_enable_in && (state == GRANT || state == START || state == BUSY)) begin
                state       <= IDLE;
                grant_out   <= '0;
                ss_out      <= '1;
                new_tx_out  <= 1'b0;
                ack_out     <= '0;
                timeout_out <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: directed checks of grant, handshake, round-robin, timeout, abort and reset
module tb_spi_xfer_arbiter;
    logic clk_in = 1'b0, rstn_in = 1'b0;
    logic [3:0] req_in = '0;
    logic [31:0] req_data_in = 32'h44A52211;
    logic core_enable_in = 1'b0, en_t = 1'b0, finished_in = 1'b0;
    logic [7:0] shift_in = 8'h00;
    logic [3:0] grant_out, ack_out, ss_out, grant_t, ack_t, ss_t;
    logic [7:0] rx_data_out, spi_dr_out, rx_t, dr_t;
    logic timeout_out, new_tx_out, timeout_t, new_tx_t;
    int n_chk = 0, n_fail = 0;
    int acks[4] = '{0, 0, 0, 0};

    always #5 clk_in = ~clk_in;

    spi_xfer_arbiter dut (
        .clk_in(clk_in), .rstn_in(rstn_in), .req_in(req_in), .req_data_in(req_data_in),
        .grant_out(grant_out), .ack_out(ack_out), .rx_data_out(rx_data_out),
        .timeout_out(timeout_out), .ss_out(ss_out), .core_enable_in(core_enable_in),
        .spi_dr_out(spi_dr_out), .new_tx_out(new_tx_out), .finished_in(finished_in),
        .shift_in(shift_in)
    );

    spi_xfer_arbiter #(.NUM_REQ(4), .TIMEOUT(15)) dut_t (
        .clk_in(clk_in), .rstn_in(rstn_in), .req_in(req_in), .req_data_in(req_data_in),
        .grant_out(grant_t), .ack_out(ack_t), .rx_data_out(rx_t),
        .timeout_out(timeout_t), .ss_out(ss_t), .core_enable_in(en_t),
        .spi_dr_out(dr_t), .new_tx_out(new_tx_t), .finished_in(finished_in),
        .shift_in(shift_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset;
        rstn_in = 1'b0;
        tick(2);
        rstn_in = 1'b1;
        tick(1);
    endtask

    initial begin
        tick(2);
        check("rst_grant", grant_out, 4'b0000);
        check("rst_ss", ss_out, 4'b1111);
        check("rst_ack", ack_out, 4'b0000);
        check("rst_rx", rx_data_out, 8'h00);
        check("rst_timeout", timeout_out, 1'b0);
        check("rst_new_tx", new_tx_out, 1'b0);
        check("rst_spi_dr", spi_dr_out, 8'h00);
        rstn_in = 1'b1;
        tick();

        // single request from requester 2, finish 20 cycles after start
        req_in = 4'b0100;
        core_enable_in = 1'b1;
        tick();
        check("single_grant", grant_out, 4'b0100);
        check("single_ss", ss_out, 4'b1011);
        check("single_no_start_yet", new_tx_out, 1'b0);
        tick();
        check("single_new_tx", new_tx_out, 1'b1);
        check("single_spi_dr", spi_dr_out, 8'hA5);
        tick();
        check("single_new_tx_pulse", new_tx_out, 1'b0);
        tick(19);
        check("single_no_early_ack", ack_out, 4'b0000);
        finished_in = 1'b1;
        shift_in = 8'h3C;
        tick();
        check("single_ack", ack_out, 4'b0100);
        check("single_rx", rx_data_out, 8'h3C);
        check("single_no_timeout", timeout_out, 1'b0);
        finished_in = 1'b0;
        req_in = 4'b0000;
        tick();
        check("single_ack_pulse", ack_out, 4'b0000);
        check("single_ss_release", ss_out, 4'b1111);
        check("single_grant_release", grant_out, 4'b0000);

        // round-robin with all four requesters held high
        do_reset();
        req_in = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("rr_grant", grant_out, 32'(1) << (i % 4));
            tick(2);
            finished_in = 1'b1;
            shift_in = 8'h50 + 8'(i);
            tick();
            check("rr_ack", ack_out, 32'(1) << (i % 4));
            check("rr_rx", rx_data_out, 8'h50 + 8'(i));
            for (int j = 0; j < 4; j++) acks[j] += int'(ack_out[j]);
            finished_in = 1'b0;
            tick();
            check("rr_ss_gap", ss_out, 4'b1111);
        end
        for (int j = 0; j < 4; j++) check("rr_ack_count", acks[j], 2);
        req_in = 4'b0000;
        tick();

        // timeout on the TIMEOUT=15 instance, finish stuck low
        core_enable_in = 1'b0;
        en_t = 1'b1;
        req_in = 4'b0010;
        shift_in = 8'hEE;
        tick();
        check("to_grant", grant_t, 4'b0010);
        tick(2);
        tick(15);
        check("to_no_early_ack", ack_t, 4'b0000);
        tick();
        check("to_ack", ack_t, 4'b0010);
        check("to_flag", timeout_t, 1'b1);
        check("to_rx", rx_t, 8'h00);
        tick();
        check("to_flag_pulse", timeout_t, 1'b0);
        check("to_ss_release", ss_t, 4'b1111);
        check("to_main_idle", grant_out, 4'b0000);
        en_t = 1'b0;
        req_in = 4'b0000;

        // abort mid-BUSY, then re-grant the same requester
        do_reset();
        core_enable_in = 1'b1;
        req_in = 4'b0110;
        tick();
        check("abort_grant", grant_out, 4'b0010);
        tick(4);
        core_enable_in = 1'b0;
        tick();
        check("abort_ss", ss_out, 4'b1111);
        check("abort_grant_rel", grant_out, 4'b0000);
        check("abort_no_ack", ack_out, 4'b0000);
        tick();
        check("abort_no_ack2", ack_out, 4'b0000);
        core_enable_in = 1'b1;
        tick();
        check("abort_regrant", grant_out, 4'b0010);
        tick(2);
        finished_in = 1'b1;
        shift_in = 8'h5A;
        tick();
        check("abort_ack", ack_out, 4'b0010);
        check("abort_rx", rx_data_out, 8'h5A);
        finished_in = 1'b0;
        tick();

        // finish already high at START must not complete the transfer
        finished_in = 1'b1;
        tick();
        check("stale_grant", grant_out, 4'b0100);
        tick(2);
        tick(3);
        check("stale_no_ack", ack_out, 4'b0000);
        finished_in = 1'b0;
        tick();
        check("stale_no_ack_fall", ack_out, 4'b0000);
        finished_in = 1'b1;
        shift_in = 8'h99;
        tick();
        check("stale_ack", ack_out, 4'b0100);
        check("stale_rx", rx_data_out, 8'h99);
        finished_in = 1'b0;
        tick();

        // asynchronous reset while BUSY
        tick();
        check("arst_grant_pre", grant_out, 4'b0010);
        tick(3);
        rstn_in = 1'b0;
        #1;
        check("arst_grant", grant_out, 4'b0000);
        check("arst_ss", ss_out, 4'b1111);
        check("arst_spi_dr", spi_dr_out, 8'h00);
        check("arst_rx", rx_data_out, 8'h00);
        check("arst_ack", ack_out, 4'b0000);
        check("arst_new_tx", new_tx_out, 1'b0);
        tick();
        rstn_in = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
